lcd_word_sequencer: RTL and testbench

- Downstream stage of the display update controller.
- On each `enable` pulse from the controller, loads the next 8-bit bus word and its D/C flag, and drives the LCD 8080-style parallel write strobe while `wr` is high.
- Raises `cmd_finished` when the last word of the current sequence has been loaded.
- Two sequence types: the init sequence (all words from the command ROM) and the frame update sequence (header words from the ROM, then pixel bytes from the pixel FIFO).

---
 rtl/lcd_word_sequencer.sv | 153 +++++++++++++++
 tb/tb_lcd_word_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_word_sequencer.sv
`timescale 1ns/1ps
// lcd_word_sequencer
// Loads one 9-bit word ({D/C, byte}) per `enable` pulse and drives the
// 8080-style LCD write strobe during the following `wr` cycle.
//
// Two sequences:
//   init   : INIT_LEN words from the command ROM, addresses 0..INIT_LEN-1
//   update : HDR_LEN header words from ROM at INIT_LEN.., then pixel bytes
//            from a first-word-fall-through FIFO, PIX_LEN words in total
//
// Ports
//   clk, nrst        clock, asynchronous active-low reset
//   enable           single-cycle request to load the next word
//   wr               write phase, high for one cycle after each enable
//   sel_init         1 = init sequence, 0 = update; sampled on first enable
//   rom_addr         address of the next ROM word (combinational)
//   rom_data         combinational ROM word {D/C, byte}
//   pix_data         FIFO head byte
//   pix_valid        FIFO not empty
//   pix_ready        FIFO pop, high in the enable cycle loading a pixel
//   lcd_d, lcd_dc    registered LCD bus and D/C line
//   lcd_wr_n         LCD write strobe, active-low
//   cmd_finished     last word of the sequence has been loaded
//   busy             a sequence is in progress
//   underrun         sticky: pixel loaded with an empty FIFO
//   wr_err           sticky: wr seen with no word loaded
module lcd_word_sequencer #(
  parameter int INIT_LEN = 40,
  parameter int PIX_LEN  = 811,
  parameter int HDR_LEN  = 11,
  parameter int CNT_W    = 10,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              wr,
  input  logic              sel_init,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [7:0]        lcd_d,
  output logic              lcd_dc,
  output logic              lcd_wr_n,
  output logic              cmd_finished,
  output logic              busy,
  output logic              underrun,
  output logic              wr_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0]  HDR_C       = CNT_W'(HDR_LEN);
  localparam logic [CNT_W-1:0]  LAST_INIT   = CNT_W'(INIT_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_PIX    = CNT_W'(PIX_LEN - 1);
  localparam logic [ADDR_W-1:0] HDR_BASE    = ADDR_W'(INIT_LEN);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             sel, sel_next;
  logic             loaded, loaded_next;
  logic [7:0]       lcd_d_next;
  logic             lcd_dc_next;
  logic             cmd_finished_next;
  logic             underrun_next;
  logic             wr_err_next;

  // Properties of the word the next enable would load. In IDLE the
  // sequence has not started yet, so the live sel_init decides.
  logic             cur_sel;
  logic [CNT_W-1:0] idx;
  logic             is_pix;
  logic             is_last;

  always_comb begin
    cur_sel  = (state == IDLE) ? sel_init : sel;
    idx      = (state == IDLE) ? '0 : count;
    is_pix   = !cur_sel && (idx >= HDR_C);
    is_last  = (idx == (cur_sel ? LAST_INIT : LAST_PIX));
    rom_addr = cur_sel ? ADDR_W'(idx) : (HDR_BASE + ADDR_W'(idx));
  end

  assign pix_ready = enable & is_pix;
  // Strobe uses the registered loaded flag, so a simultaneous enable
  // cannot strobe the word it is only now loading.
  assign lcd_wr_n  = ~(wr & loaded);
  assign busy      = (state == ACTIVE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      count        <= '0;
      sel          <= 1'b0;
      loaded       <= 1'b0;
      lcd_d        <= 8'h00;
      lcd_dc       <= 1'b1;
      cmd_finished <= 1'b0;
      underrun     <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      sel          <= sel_next;
      loaded       <= loaded_next;
      lcd_d        <= lcd_d_next;
      lcd_dc       <= lcd_dc_next;
      cmd_finished <= cmd_finished_next;
      underrun     <= underrun_next;
      wr_err       <= wr_err_next;
    end
  end

  always_comb begin
    state_next        = state;
    count_next        = count;
    sel_next          = sel;
    loaded_next       = loaded;
    lcd_d_next        = lcd_d;
    lcd_dc_next       = lcd_dc;
    cmd_finished_next = cmd_finished;
    underrun_next     = underrun;
    wr_err_next       = wr_err | (wr & ~loaded);

    if (enable) begin
      if (state == IDLE) begin
        sel_next = sel_init;
      end
      if (is_pix) begin
        lcd_dc_next = 1'b1;
        if (pix_valid) begin
          lcd_d_next = pix_data;
        end else begin
          lcd_d_next    = 8'h00;
          underrun_next = 1'b1;
        end
      end else begin
        lcd_dc_next = rom_data[8];
        lcd_d_next  = rom_data[7:0];
      end
      // A new sequence clears cmd_finished unless its first word is also
      // its last.
      cmd_finished_next = is_last;
      state_next        = is_last ? IDLE : ACTIVE;
      count_next        = is_last ? '0 : (idx + 1'b1);
      loaded_next       = 1'b1;
    end else if (wr) begin
      loaded_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_word_sequencer.sv
`timescale 1ns/1ps
module tb_lcd_word_sequencer;

  localparam int INIT_LEN = 40;
  localparam int PIX_LEN  = 811;
  localparam int HDR_LEN  = 11;

  logic       clk = 1'b0;
  logic       nrst;
  logic       enable, wr, sel_init;
  logic [5:0] rom_addr;
  logic [8:0] rom_data;
  logic [7:0] pix_data;
  logic       pix_valid, pix_ready;
  logic [7:0] lcd_d;
  logic       lcd_dc, lcd_wr_n, cmd_finished, busy, underrun, wr_err;

  lcd_word_sequencer #(
    .INIT_LEN(INIT_LEN), .PIX_LEN(PIX_LEN), .HDR_LEN(HDR_LEN),
    .CNT_W(10), .ADDR_W(6)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .wr(wr), .sel_init(sel_init),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .lcd_d(lcd_d),
    .lcd_dc(lcd_dc), .lcd_wr_n(lcd_wr_n), .cmd_finished(cmd_finished),
    .busy(busy), .underrun(underrun), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // ROM word at address a is {a[0], a}
  assign rom_data = {rom_addr[0], 2'b00, rom_addr};

  logic [7:0] fifo[$];
  int tests = 0;
  int fails = 0;
  int wr_low_cnt = 0;
  bit chk_on = 0;

  // Behavioural model: sequence position plus what the bus should show.
  bit       m_active, m_sel, m_loaded, m_fin, m_under, m_werr, m_dc;
  int       m_idx;
  logic [7:0] m_d;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] rom_word(int a);
    logic [7:0] b;
    b = a[7:0];
    return {b[0], b};
  endfunction

  task automatic model_reset();
    m_active = 0; m_sel = 0; m_loaded = 0; m_fin = 0; m_under = 0;
    m_werr = 0; m_dc = 1; m_idx = 0; m_d = 8'h00;
  endtask

  task automatic model_update(bit en, bit w, bit s_in);
    bit s;
    int i, len;
    if (w && !m_loaded) m_werr = 1;
    if (en) begin
      s = m_active ? m_sel : s_in;
      i = m_active ? m_idx : 0;
      m_sel = s;
      if (s) {m_dc, m_d} = rom_word(i);
      else if (i < HDR_LEN) {m_dc, m_d} = rom_word(INIT_LEN + i);
      else begin
        m_dc = 1;
        if (fifo.size() > 0) m_d = fifo.pop_front();
        else begin m_d = 8'h00; m_under = 1; end
      end
      len = s ? INIT_LEN : PIX_LEN;
      if (i == len - 1) begin m_active = 0; m_fin = 1; m_idx = 0; end
      else begin m_active = 1; m_fin = 0; m_idx = i + 1; end
      m_loaded = 1;
    end else if (w) begin
      m_loaded = 0;
    end
  endtask

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      bit s, pix;
      int i;
      chk("lcd_d", lcd_d, m_d);
      chk("lcd_dc", lcd_dc, m_dc);
      chk("cmd_finished", cmd_finished, m_fin);
      chk("busy", busy, m_active);
      chk("underrun", underrun, m_under);
      chk("wr_err", wr_err, m_werr);
      chk("lcd_wr_n", lcd_wr_n, !(wr && m_loaded));
      if (!lcd_wr_n) wr_low_cnt++;
      s   = m_active ? m_sel : sel_init;
      i   = m_active ? m_idx : 0;
      pix = !s && (i >= HDR_LEN);
      chk("pix_ready", pix_ready, enable && pix);
      if (!pix) chk("rom_addr", rom_addr, s ? i : INIT_LEN + i);
    end
  end

  // One clock: inputs applied 2 ns after a posedge, model stepped at the next.
  task automatic tick(bit en, bit w, bit s);
    enable    = en;
    wr        = w;
    sel_init  = s;
    pix_valid = (fifo.size() > 0);
    pix_data  = pix_valid ? fifo[0] : 8'($urandom);
    @(posedge clk);
    if (nrst) model_update(en, w, s);
    #2;
  endtask

  task automatic do_reset();
    nrst = 0; enable = 0; wr = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    nrst = 1;
  endtask

  // n enable/wr pairs; only the first enable carries the intended sel,
  // later ones carry noise that must be ignored.
  task automatic run_words(bit s, int n, bit first_sel);
    for (int k = 0; k < n; k++) begin
      tick(1'b1, 1'b0, (k == 0 && first_sel) ? s : 1'($urandom));
      tick(1'b0, 1'b1, 1'($urandom));
      repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic fill_fifo(int n, bit ramp);
    fifo.delete();
    for (int k = 0; k < n; k++) fifo.push_back(ramp ? 8'(k) : 8'($urandom));
  endtask

  initial begin
    sel_init = 0; pix_data = 0; pix_valid = 0; enable = 0; wr = 0;
    model_reset();
    nrst = 0;
    chk_on = 1;
    do_reset();
    chk("reset_dc", lcd_dc, 1);
    chk("reset_wr_n", lcd_wr_n, 1);

    // Stray wr in IDLE
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("stray_wr_err", wr_err, 1);
    chk("stray_wr_n", lcd_wr_n, 1);

    // Init run, first word stepped by hand for strobe timing
    wr_low_cnt = 0;
    tick(1'b1, 1'b0, 1'b1);
    chk("t_lcd_d_n1", lcd_d, 8'h00);
    chk("t_lcd_dc_n1", lcd_dc, 0);
    chk("t_busy", busy, 1);
    enable = 0; wr = 1; #1;
    chk("t_strobe_low", lcd_wr_n, 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("t_strobe_rise", lcd_wr_n, 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("t_lcd_d_hold", lcd_d, 8'h00);
    run_words(1'b1, INIT_LEN - 1, 1'b0);
    $display("[TB] init run done, lcd_d=%0d", lcd_d);
    chk("init_strobes", wr_low_cnt, INIT_LEN);
    chk("init_last_d", lcd_d, 8'd39);
    chk("init_last_dc", lcd_dc, 1);
    chk("init_fin", cmd_finished, 1);
    chk("init_busy", busy, 0);

    // Update run with 800 ramp bytes
    fill_fifo(800, 1'b1);
    wr_low_cnt = 0;
    run_words(1'b0, PIX_LEN, 1'b1);
    $display("[TB] update run done, fifo=%0d", fifo.size());
    chk("upd_strobes", wr_low_cnt, PIX_LEN);
    chk("upd_fifo_empty", fifo.size(), 0);
    chk("upd_last_d", lcd_d, 8'h1F);
    chk("upd_under", underrun, 0);
    chk("upd_fin", cmd_finished, 1);

    // Underrun: only 5 pixels available
    fill_fifo(5, 1'b0);
    run_words(1'b0, PIX_LEN, 1'b1);
    $display("[TB] underrun run done, underrun=%0d", underrun);
    chk("ur_flag", underrun, 1);
    chk("ur_last_d", lcd_d, 8'h00);
    chk("ur_fin", cmd_finished, 1);

    // Reset after 20 init words
    run_words(1'b1, 20, 1'b1);
    nrst = 0; enable = 0; wr = 0;
    model_reset();
    #1;
    chk("rst_d", lcd_d, 8'h00);
    chk("rst_dc", lcd_dc, 1);
    chk("rst_wr_n", lcd_wr_n, 1);
    chk("rst_fin", cmd_finished, 0);
    chk("rst_busy", busy, 0);
    chk("rst_under", underrun, 0);
    chk("rst_wr_err", wr_err, 0);
    @(posedge clk); #2;
    nrst = 1;
    sel_init = 0; #1;
    chk("rst_rom_addr", rom_addr, 6'd40);
    fill_fifo(800, 1'b0);
    run_words(1'b0, PIX_LEN, 1'b1);
    $display("[TB] post-reset update done, fin=%0d", cmd_finished);
    chk("post_fin", cmd_finished, 1);

    // Random back-to-back sequences
    for (int r = 0; r < 3; r++) begin
      bit s;
      s = 1'($urandom);
      fill_fifo($urandom_range(790, 800), 1'b0);
      run_words(s, s ? INIT_LEN : PIX_LEN, 1'b1);
      $display("[TB] random seq %0d sel=%0d done", r, s);
    end

    tick(1'b0, 1'b0, 1'b0);
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
